// File: rtl/clock_reset_sequencer_if.sv
// Signal bundle between the PLL bring-up sequencer and the clock generator /
// video pipeline. The sequencer uses the master modport.
interface clock_reset_sequencer_if;
  // Raw, asynchronous lock indications from the clock generator
  logic       PllLocked1;
  logic       PllLocked2;
  logic       BufpllLock;
  // PLL resets and pipeline reset request
  logic       PllRst1;
  logic       PllRst2;
  logic       SysRstN;
  // Status
  logic       Ready;
  logic       Fault;
  logic [2:0] RetryCnt;
  logic [7:0] LossCount;
  logic [2:0] State;

  modport master (
    input  PllLocked1, PllLocked2, BufpllLock,
    output PllRst1, PllRst2, SysRstN, Ready, Fault, RetryCnt, LossCount, State
  );

  modport slave (
    output PllLocked1, PllLocked2, BufpllLock,
    input  PllRst1, PllRst2, SysRstN, Ready, Fault, RetryCnt, LossCount, State
  );
endinterface

// File: rtl/clock_reset_sequencer.sv
// Bring-up sequencer for the cascaded prescaler PLL and pixel/serializer PLL
// (feeding the BUFPLL). Pulses each PLL reset in turn, waits for lock with a
// timeout, holds the pixel-domain reset until all locks have been stable for
// a settle window, then watches for lock loss and restarts on loss.
// Optional build macro CLKSEQ_STATUS_EN makes LossCount and State live;
// without it both read as zero and the loss counter is not built.
module clock_reset_sequencer #(
  parameter int unsigned RST_CYCLES    = 32,
  parameter int unsigned LOCK_TIMEOUT  = 65535,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned LOSS_FILTER   = 4,
  parameter int unsigned MAX_RETRY     = 7
) (
  input  logic                    CLK32,
  input  logic                    RstN,
  clock_reset_sequencer_if.master seq
);

  localparam int unsigned CNT_W   = 17;
  localparam int unsigned RETRY_W = 3;
  localparam int unsigned LOSS_W  = 8;
  localparam int unsigned ST_W    = 3;
  localparam int unsigned NLOCK   = 3;
  localparam int unsigned FILT_W  = $clog2(LOSS_FILTER + 1);

  typedef enum logic [ST_W-1:0] {
    ST_RESET_PLL1 = 3'd0,
    ST_WAIT_LOCK1 = 3'd1,
    ST_RESET_PLL2 = 3'd2,
    ST_WAIT_LOCK2 = 3'd3,
    ST_SETTLE     = 3'd4,
    ST_RUN        = 3'd5,
    ST_FAULT      = 3'd6
  } state_e;

  // Lock synchronisers: bit 0 = PLL1, bit 1 = PLL2, bit 2 = BUFPLL
  logic [NLOCK-1:0]   lock_raw;
  logic [NLOCK-1:0]   sync_meta_q;
  logic [NLOCK-1:0]   sync_q;
  logic               l1;
  logic               l2;
  logic               lb;

  state_e             state_q;
  state_e             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [RETRY_W-1:0] retry_q;
  logic [RETRY_W-1:0] retry_d;
  logic               retry_evt;

  // Per-lock low-run counters used only in RUN
  logic [FILT_W-1:0]  low_q [NLOCK];
  logic               loss_hit;

  // Registered outputs and their next values
  logic               pll_rst1_q;
  logic               pll_rst2_q;
  logic               sys_rst_n_q;
  logic               ready_q;
  logic               fault_q;
  logic               pll_rst1_d;
  logic               pll_rst2_d;
  logic               sys_rst_n_d;
  logic               ready_d;
  logic               fault_d;

  assign lock_raw = {seq.BufpllLock, seq.PllLocked2, seq.PllLocked1};
  assign l1       = sync_q[0];
  assign l2       = sync_q[1];
  assign lb       = sync_q[2];

  // Two-flop synchronisers on the asynchronous lock inputs
  always_ff @(posedge CLK32 or negedge RstN) begin
    if (!RstN) begin
      sync_meta_q <= '0;
      sync_q      <= '0;
    end else begin
      sync_meta_q <= lock_raw;
      sync_q      <= sync_meta_q;
    end
  end

  // Low-run counters: count consecutive low synced samples while in RUN
  always_ff @(posedge CLK32 or negedge RstN) begin
    if (!RstN) begin
      for (int i = 0; i < NLOCK; i++) low_q[i] <= '0;
    end else begin
      for (int i = 0; i < NLOCK; i++) begin
        if (state_q != ST_RUN || sync_q[i]) begin
          low_q[i] <= '0;
        end else if (low_q[i] != FILT_W'(LOSS_FILTER)) begin
          low_q[i] <= low_q[i] + 1'b1;
        end
      end
    end
  end

  // Any lock whose low run has reached the filter depth is a loss
  always_comb begin
    loss_hit = 1'b0;
    for (int i = 0; i < NLOCK; i++) begin
      if (low_q[i] == FILT_W'(LOSS_FILTER)) loss_hit = 1'b1;
    end
  end

  // Next-state, retry accounting and output decode of the next state
  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    retry_evt   = 1'b0;
    pll_rst1_d  = 1'b1;
    pll_rst2_d  = 1'b1;
    sys_rst_n_d = 1'b0;
    ready_d     = 1'b0;
    fault_d     = 1'b0;

    case (state_q)
      ST_RESET_PLL1: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = ST_WAIT_LOCK1;
      end
      ST_WAIT_LOCK1: begin
        // A lock arriving together with the timeout takes precedence
        if (l1) begin
          state_d = ST_RESET_PLL2;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT)) begin
          retry_evt = 1'b1;
        end
      end
      ST_RESET_PLL2: begin
        if (!l1) begin
          retry_evt = 1'b1;
        end else if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          state_d = ST_WAIT_LOCK2;
        end
      end
      ST_WAIT_LOCK2: begin
        // Abort and timeout together still count as a single retry
        if (!l1) begin
          retry_evt = 1'b1;
        end else if (l2 && lb) begin
          state_d = ST_SETTLE;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT)) begin
          retry_evt = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (!(l1 && l2 && lb)) begin
          retry_evt = 1'b1;
        end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = ST_RUN;
          retry_d = '0;
        end
      end
      ST_RUN: begin
        if (loss_hit) state_d = ST_RESET_PLL1;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_RESET_PLL1;
      end
    endcase

    if (retry_evt) begin
      if (retry_q == RETRY_W'(MAX_RETRY)) begin
        state_d = ST_FAULT;
      end else begin
        retry_d = retry_q + 1'b1;
        state_d = ST_RESET_PLL1;
      end
    end

    case (state_d)
      ST_WAIT_LOCK1: begin
        pll_rst1_d = 1'b0;
      end
      ST_RESET_PLL2: begin
        pll_rst1_d = 1'b0;
      end
      ST_WAIT_LOCK2, ST_SETTLE: begin
        pll_rst1_d = 1'b0;
        pll_rst2_d = 1'b0;
      end
      ST_RUN: begin
        pll_rst1_d  = 1'b0;
        pll_rst2_d  = 1'b0;
        sys_rst_n_d = 1'b1;
        ready_d     = 1'b1;
      end
      ST_FAULT: begin
        fault_d = 1'b1;
      end
      default: begin
        pll_rst1_d = 1'b1;
        pll_rst2_d = 1'b1;
      end
    endcase
  end

  // State register, shared cycle counter, retry count and output registers
  always_ff @(posedge CLK32 or negedge RstN) begin
    if (!RstN) begin
      state_q     <= ST_RESET_PLL1;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_rst1_q  <= 1'b1;
      pll_rst2_q  <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      retry_q     <= retry_d;
      pll_rst1_q  <= pll_rst1_d;
      pll_rst2_q  <= pll_rst2_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign seq.PllRst1  = pll_rst1_q;
  assign seq.PllRst2  = pll_rst2_q;
  assign seq.SysRstN  = sys_rst_n_q;
  assign seq.Ready    = ready_q;
  assign seq.Fault    = fault_q;
  assign seq.RetryCnt = retry_q;

`ifdef CLKSEQ_STATUS_EN
  logic [LOSS_W-1:0] loss_cnt_q;

  // Saturating count of lock-loss events seen in RUN
  always_ff @(posedge CLK32 or negedge RstN) begin
    if (!RstN) begin
      loss_cnt_q <= '0;
    end else if (state_q == ST_RUN && loss_hit && loss_cnt_q != '1) begin
      loss_cnt_q <= loss_cnt_q + 1'b1;
    end
  end

  assign seq.LossCount = loss_cnt_q;
  assign seq.State     = ST_W'(state_q);
`else
  assign seq.LossCount = '0;
  assign seq.State     = '0;
`endif

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Directed bench for clock_reset_sequencer: bring-up timing, lock-loss
// glitch filter, settle abort, asynchronous reset mid-sequence, retry
// exhaustion into FAULT. Status outputs are expected live only when
// CLKSEQ_STATUS_EN is defined.
module tb_clock_reset_sequencer;

  localparam int unsigned RST_CYCLES    = 4;
  localparam int unsigned LOCK_TIMEOUT  = 200;
  localparam int unsigned SETTLE_CYCLES = 16;
  localparam int unsigned LOSS_FILTER   = 4;
  localparam int unsigned MAX_RETRY     = 7;

`ifdef CLKSEQ_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif
  localparam logic [2:0] EXP_ST_RUN   = STATUS_EN ? 3'd5 : 3'd0;
  localparam logic [2:0] EXP_ST_FAULT = STATUS_EN ? 3'd6 : 3'd0;
  localparam logic [7:0] EXP_LOSS_ONE = STATUS_EN ? 8'd1 : 8'd0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  clock_reset_sequencer_if bus();

  clock_reset_sequencer #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .LOSS_FILTER  (LOSS_FILTER),
    .MAX_RETRY    (MAX_RETRY)
  ) dut (
    .CLK32(clk),
    .RstN (rst_n),
    .seq  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_locks(input logic a, input logic b, input logic c);
    bus.PllLocked1 = a;
    bus.PllLocked2 = b;
    bus.BufpllLock = c;
  endtask

  // Hold reset for a few cycles with the given raw locks, release just after an edge
  task automatic reset_and_release(input logic a, input logic b, input logic c);
    rst_n = 1'b0;
    set_locks(a, b, c);
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_locks(1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    checks++;
    if ({bus.PllRst1, bus.PllRst2, bus.SysRstN, bus.Ready, bus.Fault} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_levels: got %b expected 11000",
               {bus.PllRst1, bus.PllRst2, bus.SysRstN, bus.Ready, bus.Fault});
    end
    checks++;
    if (bus.RetryCnt !== 3'd0 || bus.LossCount !== 8'd0 || bus.State !== 3'd0) begin
      errors++;
      $display("FAIL reset_counters: retry=%0d loss=%0d state=%0d expected 0/0/0",
               bus.RetryCnt, bus.LossCount, bus.State);
    end
  endtask

  task automatic test_bring_up();
    int n;
    rst_n = 1'b1;
    n = 0;
    do begin tick(); n++; end while (bus.PllRst1 === 1'b1 && n < 50);
    checks++;
    if (n != RST_CYCLES) begin
      errors++;
      $display("FAIL bringup_pllrst1_width: got %0d expected %0d", n, RST_CYCLES);
    end
    repeat (10) tick();
    bus.PllLocked1 = 1'b1;
    n = 0;
    do begin tick(); n++; end while (bus.PllRst2 === 1'b1 && n < 50);
    checks++;
    if (n != 3 + RST_CYCLES) begin
      errors++;
      $display("FAIL bringup_pllrst2_fall: got %0d expected %0d", n, 3 + RST_CYCLES);
    end
    repeat (20) tick();
    bus.PllLocked2 = 1'b1;
    bus.BufpllLock = 1'b1;
    n = 0;
    do begin tick(); n++; end while (bus.SysRstN !== 1'b1 && n < 100);
    checks++;
    if (n != 3 + SETTLE_CYCLES) begin
      errors++;
      $display("FAIL bringup_sysrstn_rise: got %0d expected %0d", n, 3 + SETTLE_CYCLES);
    end
    checks++;
    if (bus.Ready !== 1'b1 || bus.RetryCnt !== 3'd0 || bus.Fault !== 1'b0 || bus.State !== EXP_ST_RUN) begin
      errors++;
      $display("FAIL bringup_run_status: ready=%b retry=%0d fault=%b state=%0d expected 1/0/0/%0d",
               bus.Ready, bus.RetryCnt, bus.Fault, bus.State, EXP_ST_RUN);
    end
  endtask

  task automatic test_glitch_filter();
    int n;
    int bad;
    bus.PllLocked2 = 1'b0;
    repeat (3) tick();
    bus.PllLocked2 = 1'b1;
    bad = 0;
    repeat (20) begin
      tick();
      if (bus.SysRstN !== 1'b1 || bus.Ready !== 1'b1 || bus.PllRst1 !== 1'b0 || bus.LossCount !== 8'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL glitch_short_ignored: got %0d disturbed cycles expected 0", bad);
    end
    bus.PllLocked2 = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
      if (n == LOSS_FILTER) bus.PllLocked2 = 1'b1;
    end while (bus.SysRstN === 1'b1 && n < 50);
    checks++;
    if (n != LOSS_FILTER + 3) begin
      errors++;
      $display("FAIL glitch_loss_latency: got %0d expected %0d", n, LOSS_FILTER + 3);
    end
    checks++;
    if (bus.PllRst1 !== 1'b1 || bus.Ready !== 1'b0 || bus.LossCount !== EXP_LOSS_ONE || bus.State !== 3'd0) begin
      errors++;
      $display("FAIL glitch_loss_state: pllrst1=%b ready=%b loss=%0d state=%0d expected 1/0/%0d/0",
               bus.PllRst1, bus.Ready, bus.LossCount, bus.State, EXP_LOSS_ONE);
    end
    n = 0;
    do begin tick(); n++; end while (bus.PllRst1 === 1'b1 && n < 50);
    checks++;
    if (n != RST_CYCLES) begin
      errors++;
      $display("FAIL glitch_repulse_width: got %0d expected %0d", n, RST_CYCLES);
    end
    n = 0;
    do begin tick(); n++; end while (bus.SysRstN !== 1'b1 && n < 100);
    checks++;
    if (n != 2 + RST_CYCLES + SETTLE_CYCLES) begin
      errors++;
      $display("FAIL glitch_rerun_time: got %0d expected %0d", n, 2 + RST_CYCLES + SETTLE_CYCLES);
    end
    checks++;
    if (bus.LossCount !== EXP_LOSS_ONE || bus.RetryCnt !== 3'd0) begin
      errors++;
      $display("FAIL glitch_rerun_counts: loss=%0d retry=%0d expected %0d/0",
               bus.LossCount, bus.RetryCnt, EXP_LOSS_ONE);
    end
  endtask

  task automatic test_settle_abort();
    int n;
    int bad;
    reset_and_release(1'b1, 1'b0, 1'b0);
    n = 0;
    do begin tick(); n++; end while (bus.PllRst2 === 1'b1 && n < 50);
    bus.PllLocked2 = 1'b1;
    bus.BufpllLock = 1'b1;
    bad = 0;
    repeat (9) begin
      tick();
      if (bus.SysRstN !== 1'b0) bad++;
    end
    bus.BufpllLock = 1'b0;
    tick();
    if (bus.SysRstN !== 1'b0) bad++;
    bus.BufpllLock = 1'b1;
    tick();
    if (bus.SysRstN !== 1'b0) bad++;
    checks++;
    if (bus.PllRst1 !== 1'b0) begin
      errors++;
      $display("FAIL abort_not_early: got pllrst1=%b expected 0", bus.PllRst1);
    end
    tick();
    if (bus.SysRstN !== 1'b0) bad++;
    checks++;
    if (bus.PllRst1 !== 1'b1 || bus.RetryCnt !== 3'd1 || bus.State !== 3'd0) begin
      errors++;
      $display("FAIL abort_restart: pllrst1=%b retry=%0d state=%0d expected 1/1/0",
               bus.PllRst1, bus.RetryCnt, bus.State);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abort_sysrstn_low: got %0d high cycles expected 0", bad);
    end
    n = 0;
    do begin tick(); n++; end while (bus.SysRstN !== 1'b1 && n < 100);
    checks++;
    if (n != 2 + 2 * RST_CYCLES + SETTLE_CYCLES || bus.RetryCnt !== 3'd0) begin
      errors++;
      $display("FAIL abort_recover: got %0d cycles retry=%0d expected %0d cycles retry=0",
               n, bus.RetryCnt, 2 + 2 * RST_CYCLES + SETTLE_CYCLES);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    reset_and_release(1'b1, 1'b0, 1'b0);
    n = 0;
    do begin tick(); n++; end while (bus.PllRst2 === 1'b1 && n < 50);
    checks++;
    if (n != 2 * RST_CYCLES + 1 || bus.PllRst1 !== 1'b0) begin
      errors++;
      $display("FAIL midreset_reach_wait2: got %0d pllrst1=%b expected %0d/0", n, bus.PllRst1, 2 * RST_CYCLES + 1);
    end
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.PllRst1, bus.PllRst2, bus.SysRstN, bus.Ready, bus.Fault} !== 5'b11000 ||
        bus.RetryCnt !== 3'd0 || bus.State !== 3'd0 || bus.LossCount !== 8'd0) begin
      errors++;
      $display("FAIL midreset_async: got %b retry=%0d state=%0d expected 11000 retry=0 state=0",
               {bus.PllRst1, bus.PllRst2, bus.SysRstN, bus.Ready, bus.Fault}, bus.RetryCnt, bus.State);
    end
    bus.PllLocked2 = 1'b1;
    bus.BufpllLock = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    n = 0;
    do begin tick(); n++; end while (bus.PllRst1 === 1'b1 && n < 50);
    checks++;
    if (n != RST_CYCLES) begin
      errors++;
      $display("FAIL midreset_pllrst1_width: got %0d expected %0d", n, RST_CYCLES);
    end
    do begin tick(); n++; end while (bus.SysRstN !== 1'b1 && n < 100);
    checks++;
    if (n != 2 * RST_CYCLES + 2 + SETTLE_CYCLES) begin
      errors++;
      $display("FAIL midreset_full_sequence: got %0d expected %0d", n, 2 * RST_CYCLES + 2 + SETTLE_CYCLES);
    end
  endtask

  task automatic test_no_lock_fault();
    int n;
    int pulses;
    int bad;
    logic prev;
    logic [2:0] first_retry;
    reset_and_release(1'b0, 1'b0, 1'b0);
    n = 0;
    do begin tick(); n++; end while (bus.PllRst1 === 1'b1 && n < 50);
    prev = bus.PllRst1;
    pulses = 0;
    first_retry = 3'd0;
    n = 0;
    while (bus.Fault !== 1'b1 && n < 4000) begin
      tick();
      n++;
      if (bus.Fault === 1'b0 && bus.PllRst1 === 1'b1 && prev === 1'b0) begin
        pulses++;
        if (pulses == 1) first_retry = bus.RetryCnt;
      end
      prev = bus.PllRst1;
    end
    checks++;
    if (pulses != MAX_RETRY) begin
      errors++;
      $display("FAIL nolock_restart_pulses: got %0d expected %0d", pulses, MAX_RETRY);
    end
    checks++;
    if (first_retry !== 3'd1) begin
      errors++;
      $display("FAIL nolock_first_retry: got %0d expected 1", first_retry);
    end
    checks++;
    if ({bus.Fault, bus.PllRst1, bus.PllRst2, bus.SysRstN, bus.Ready} !== 5'b11100 ||
        bus.RetryCnt !== 3'd7 || bus.State !== EXP_ST_FAULT) begin
      errors++;
      $display("FAIL nolock_fault_state: got %b retry=%0d state=%0d expected 11100 retry=7 state=%0d",
               {bus.Fault, bus.PllRst1, bus.PllRst2, bus.SysRstN, bus.Ready}, bus.RetryCnt, bus.State, EXP_ST_FAULT);
    end
    set_locks(1'b1, 1'b1, 1'b1);
    bad = 0;
    repeat (300) begin
      tick();
      if (bus.Fault !== 1'b1 || bus.PllRst1 !== 1'b1 || bus.SysRstN !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL nolock_fault_sticky: got %0d cycles out of FAULT expected 0", bad);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.Fault !== 1'b0 || bus.RetryCnt !== 3'd0 || bus.PllRst1 !== 1'b1) begin
      errors++;
      $display("FAIL nolock_fault_cleared: fault=%b retry=%0d pllrst1=%b expected 0/0/1",
               bus.Fault, bus.RetryCnt, bus.PllRst1);
    end
  endtask

  initial begin
    test_reset();
    test_bring_up();
    test_glitch_filter();
    test_settle_abort();
    test_reset_mid();
    test_no_lock_fault();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1);
  end

endmodule
